// File: rtl/trivium_pkg.sv
// rtl/trivium_pkg.sv - Trivium constants, tap positions, FSM encodings and state loader
package trivium_pkg;

   localparam int KEY_BITS       = 80;
   localparam int IV_BITS        = 80;
   localparam int STATE_BITS     = 288;
   localparam int ROUNDS_PER_CLK = 8;

   // Tap positions, 1-based as in the Trivium description (s1..s288)
   localparam int TAP_A_OUT0 = 66;
   localparam int TAP_A_OUT1 = 93;
   localparam int TAP_A_AND0 = 91;
   localparam int TAP_A_AND1 = 92;
   localparam int TAP_A_FB   = 171;
   localparam int TAP_B_OUT0 = 162;
   localparam int TAP_B_OUT1 = 177;
   localparam int TAP_B_AND0 = 175;
   localparam int TAP_B_AND1 = 176;
   localparam int TAP_B_FB   = 264;
   localparam int TAP_C_OUT0 = 243;
   localparam int TAP_C_OUT1 = 288;
   localparam int TAP_C_AND0 = 286;
   localparam int TAP_C_AND1 = 287;
   localparam int TAP_C_FB   = 69;

   // Register heads: s1 (C feedback), s94 (A feedback), s178 (B feedback)
   localparam int HEAD_B = 94;
   localparam int HEAD_C = 178;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] INIT = 2'd2;
   localparam logic [1:0] RUN  = 2'd3;

   // Bit n-1 of the vector holds s_n; key in s1..s80, IV in s94..s173, s286..s288 = 1
   function automatic logic [STATE_BITS-1:0] load_state(input logic [KEY_BITS-1:0] key,
                                                        input logic [IV_BITS-1:0] iv);
      logic [STATE_BITS-1:0] s;
      s = '0;
      s[KEY_BITS-1:0] = key;
      s[HEAD_B-1 +: IV_BITS] = iv;
      s[STATE_BITS-1 -: 3] = 3'b111;
      return s;
   endfunction

endpackage

// File: rtl/trivium_round8.sv
// rtl/trivium_round8.sv - eight unrolled Trivium rounds, combinational
module trivium_round8
   import trivium_pkg::*;
(
   input  logic [STATE_BITS-1:0] state_in,
   output logic [STATE_BITS-1:0] state_out,
   output logic [ROUNDS_PER_CLK-1:0] z
);

   logic [STATE_BITS-1:0] s;
   logic t1, t2, t3;
   logic n1, n2, n3;

   // Apply the rounds in sequence; z[k] is the keystream bit of round k
   always_comb begin
      s  = state_in;
      z  = '0;
      t1 = 1'b0;
      t2 = 1'b0;
      t3 = 1'b0;
      n1 = 1'b0;
      n2 = 1'b0;
      n3 = 1'b0;
      for (int k = 0; k < ROUNDS_PER_CLK; k++) begin
         t1 = s[TAP_A_OUT0-1] ^ s[TAP_A_OUT1-1];
         t2 = s[TAP_B_OUT0-1] ^ s[TAP_B_OUT1-1];
         t3 = s[TAP_C_OUT0-1] ^ s[TAP_C_OUT1-1];
         z[k] = t1 ^ t2 ^ t3;
         n1 = t1 ^ (s[TAP_A_AND0-1] & s[TAP_A_AND1-1]) ^ s[TAP_A_FB-1];
         n2 = t2 ^ (s[TAP_B_AND0-1] & s[TAP_B_AND1-1]) ^ s[TAP_B_FB-1];
         n3 = t3 ^ (s[TAP_C_AND0-1] & s[TAP_C_AND1-1]) ^ s[TAP_C_FB-1];
         // Whole-vector shift moves every register by one; the three heads are then overwritten
         s = {s[STATE_BITS-2:0], 1'b0};
         s[0]        = n3;
         s[HEAD_B-1] = n1;
         s[HEAD_C-1] = n2;
      end
      state_out = s;
   end

endmodule

// File: rtl/trivium_stream_decrypt.sv
// rtl/trivium_stream_decrypt.sv - byte-wide Trivium decryptor; TRIVIUM_DEBUG_TAP_EN adds ks_dbg
module trivium_stream_decrypt
   import trivium_pkg::*;
#(
   parameter int WARMUP_CYCLES = 144,
   parameter int CFG_BYTES     = 20
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cfg_start,
   input  logic       cfg_valid,
   input  logic [7:0] cfg_data,
   input  logic       ct_valid,
   input  logic [7:0] ct_data,
   output logic       ct_ready,
   output logic       pt_valid,
   output logic [7:0] pt_data,
   input  logic       pt_ready,
   output logic       busy,
   output logic       run
`ifdef TRIVIUM_DEBUG_TAP_EN
   ,
   output logic [7:0] ks_dbg
`endif
);

   logic [1:0]            fsm;
   logic [STATE_BITS-1:0] state;
   logic [STATE_BITS-1:0] state_next;
   logic [7:0]            z;
   logic [151:0]          cfg_buf;
   logic [159:0]          buf_next;
   logic [4:0]            cfg_cnt;
   logic [7:0]            warm_cnt;
   logic                  ct_fire;

   trivium_round8 u_round8 (
      .state_in  (state),
      .state_out (state_next),
      .z         (z)
   );

   // Byte 0 ends up in bits [7:0] once all 20 bytes have been shifted in from the top
   assign buf_next = {cfg_data, cfg_buf};
   assign busy     = (fsm == INIT);
   assign run      = (fsm == RUN);
   assign ct_ready = run && (!pt_valid || pt_ready);
   assign ct_fire  = ct_valid && ct_ready;

   // Config loading, warm-up and keystream stepping; the state only moves on INIT clocks or ct handshakes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm      <= IDLE;
         state    <= '0;
         cfg_buf  <= '0;
         cfg_cnt  <= '0;
         warm_cnt <= '0;
         pt_valid <= 1'b0;
         pt_data  <= '0;
      end else if (cfg_start) begin
         fsm      <= IDLE;
         state    <= '0;
         cfg_cnt  <= '0;
         warm_cnt <= '0;
         pt_valid <= 1'b0;
      end else begin
         case (fsm)
            IDLE, LOAD: begin
               if (cfg_valid) begin
                  cfg_buf <= buf_next[159:8];
                  cfg_cnt <= cfg_cnt + 5'd1;
                  if (cfg_cnt == 5'(CFG_BYTES - 1)) begin
                     state    <= load_state(buf_next[KEY_BITS-1:0], buf_next[159:KEY_BITS]);
                     warm_cnt <= '0;
                     fsm      <= INIT;
                  end else begin
                     fsm <= LOAD;
                  end
               end
            end
            INIT: begin
               state    <= state_next;
               warm_cnt <= warm_cnt + 8'd1;
               if (warm_cnt == 8'(WARMUP_CYCLES - 1)) begin
                  fsm <= RUN;
               end
            end
            default: begin
               if (ct_fire) begin
                  state    <= state_next;
                  pt_data  <= ct_data ^ z;
                  pt_valid <= 1'b1;
               end else if (pt_ready) begin
                  pt_valid <= 1'b0;
               end
            end
         endcase
      end
   end

`ifdef TRIVIUM_DEBUG_TAP_EN
   // Keystream byte used at the most recent ct handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ks_dbg <= '0;
      end else if (cfg_start) begin
         ks_dbg <= '0;
      end else if (ct_fire) begin
         ks_dbg <= z;
      end
   end
`endif

endmodule

// File: tb/tb_trivium_stream_decrypt.sv
// tb/tb_trivium_stream_decrypt.sv - directed bench for trivium_stream_decrypt with a bit-level keystream model
module tb_trivium_stream_decrypt;

   logic       clk;
   logic       rst_n;
   logic       cfg_start;
   logic       cfg_valid;
   logic [7:0] cfg_data;
   logic       ct_valid;
   logic [7:0] ct_data;
   logic       ct_ready;
   logic       pt_valid;
   logic [7:0] pt_data;
   logic       pt_ready;
   logic       busy;
   logic       run;
`ifdef TRIVIUM_DEBUG_TAP_EN
   logic [7:0] ks_dbg;
`endif

   int total = 0;
   int bad   = 0;

   bit ms [1:288];

   trivium_stream_decrypt dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_data  (cfg_data),
      .ct_valid  (ct_valid),
      .ct_data   (ct_data),
      .ct_ready  (ct_ready),
      .pt_valid  (pt_valid),
      .pt_data   (pt_data),
      .pt_ready  (pt_ready),
      .busy      (busy),
      .run       (run)
`ifdef TRIVIUM_DEBUG_TAP_EN
      ,
      .ks_dbg    (ks_dbg)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic m_step(output bit zb);
      bit t1, t2, t3;
      t1 = ms[66] ^ ms[93];
      t2 = ms[162] ^ ms[177];
      t3 = ms[243] ^ ms[288];
      zb = t1 ^ t2 ^ t3;
      t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
      t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
      t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
      for (int i = 288; i > 1; i--) ms[i] = ms[i-1];
      ms[1]   = t3;
      ms[94]  = t1;
      ms[178] = t2;
   endtask

   task automatic m_load(input logic [79:0] key, input logic [79:0] iv);
      bit zb;
      for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
      for (int i = 1; i <= 80; i++) begin
         ms[i]      = key[i-1];
         ms[93 + i] = iv[i-1];
      end
      ms[286] = 1'b1;
      ms[287] = 1'b1;
      ms[288] = 1'b1;
      repeat (1152) m_step(zb);
   endtask

   task automatic m_byte(output logic [7:0] ks);
      bit zb;
      for (int k = 0; k < 8; k++) begin
         m_step(zb);
         ks[k] = zb;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cfg(input logic [79:0] key, input logic [79:0] iv, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         cfg_valid = 1'b1;
         cfg_data  = (i < 10) ? key[8*i +: 8] : iv[8*(i-10) +: 8];
         tick();
      end
      cfg_valid = 1'b0;
   endtask

   task automatic pulse_start();
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   task automatic wait_run(input string name);
      int n;
      n = 0;
      while (!run && n < 400) begin
         tick();
         n++;
      end
      total++;
      if (run !== 1'b1) begin
         bad++;
         $display("FAIL %s_wait_run: run=%b after %0d cycles, required 1", name, run, n);
      end
   endtask

   task automatic test_reset();
      total++;
      if ({ct_ready, pt_valid, pt_data, busy, run} !== 12'h000) begin
         bad++;
         $display("FAIL reset_outputs: ct_ready=%b pt_valid=%b pt_data=%h busy=%b run=%b, required all 0",
                  ct_ready, pt_valid, pt_data, busy, run);
      end
`ifdef TRIVIUM_DEBUG_TAP_EN
      total++;
      if (ks_dbg !== 8'h00) begin
         bad++;
         $display("FAIL reset_ks_dbg: got %h required 00", ks_dbg);
      end
`endif
   endtask

   task automatic test_zero_key();
      logic [7:0] ks;
      int n;
      m_load(80'h0, 80'h0);
      pt_ready = 1'b1;
      send_cfg(80'h0, 80'h0, 0, 18);
      ct_valid = 1'b1;
      ct_data  = 8'h00;
      total++;
      if ({busy, run, ct_ready} !== 3'b000) begin
         bad++;
         $display("FAIL load_flags: busy=%b run=%b ct_ready=%b, required 000", busy, run, ct_ready);
      end
      send_cfg(80'h0, 80'h0, 19, 19);
      n = 0;
      while (busy && n < 300) begin
         total++;
         if (ct_ready !== 1'b0) begin
            bad++;
            $display("FAIL init_ct_ready: got %b required 0 at init cycle %0d", ct_ready, n);
         end
         n++;
         tick();
      end
      total++;
      if (n !== 144) begin
         bad++;
         $display("FAIL busy_cycles: got %0d required 144", n);
      end
      total++;
      if ({run, pt_valid, ct_ready} !== 3'b101) begin
         bad++;
         $display("FAIL run_entry: run=%b pt_valid=%b ct_ready=%b, required 1 0 1", run, pt_valid, ct_ready);
      end
      for (int i = 0; i < 8; i++) begin
         ct_data = 8'h00;
         tick();
         m_byte(ks);
         total++;
         if (pt_valid !== 1'b1 || pt_data !== ks) begin
            bad++;
            $display("FAIL zero_key_ks%0d: pt_valid=%b pt_data=%h, required 1 %h", i, pt_valid, pt_data, ks);
         end
`ifdef TRIVIUM_DEBUG_TAP_EN
         total++;
         if (ks_dbg !== ks) begin
            bad++;
            $display("FAIL zero_key_ks_dbg%0d: got %h required %h", i, ks_dbg, ks);
         end
`endif
      end
      ct_valid = 1'b0;
      tick();
      total++;
      if (pt_valid !== 1'b0) begin
         bad++;
         $display("FAIL zero_key_drain: pt_valid=%b required 0", pt_valid);
      end
   endtask

   task automatic test_hello();
      logic [7:0] msg [5];
      logic [7:0] ks  [5];
      logic [79:0] key;
      msg[0] = 8'h48; msg[1] = 8'h45; msg[2] = 8'h4C; msg[3] = 8'h4C; msg[4] = 8'h4F;
      key = 80'h0;
      key[7] = 1'b1;
      m_load(key, 80'h0);
      for (int i = 0; i < 5; i++) m_byte(ks[i]);
      pulse_start();
      send_cfg(key, 80'h0, 0, 19);
      wait_run("hello");
      pt_ready = 1'b1;
      ct_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ct_data = msg[i] ^ ks[i];
         tick();
         total++;
         if (pt_valid !== 1'b1 || pt_data !== msg[i]) begin
            bad++;
            $display("FAIL hello_byte%0d: pt_valid=%b pt_data=%h, required 1 %h", i, pt_valid, pt_data, msg[i]);
         end
`ifdef TRIVIUM_DEBUG_TAP_EN
         total++;
         if (ks_dbg !== (pt_data ^ ct_data)) begin
            bad++;
            $display("FAIL hello_ks_dbg%0d: got %h required %h", i, ks_dbg, pt_data ^ ct_data);
         end
`endif
      end
      ct_valid = 1'b0;
      tick();
   endtask

   task automatic test_stall();
      logic [79:0] key, iv;
      logic [7:0] ks0, ks1;
      key = 80'h0123456789ABCDEF0011;
      iv  = 80'h0A0B0C0D0E0F10111213;
      m_load(key, iv);
      m_byte(ks0);
      m_byte(ks1);
      pulse_start();
      send_cfg(key, iv, 0, 19);
      wait_run("stall");
      pt_ready = 1'b0;
      ct_valid = 1'b1;
      ct_data  = 8'h5A;
      tick();
      total++;
      if (pt_valid !== 1'b1 || pt_data !== (8'h5A ^ ks0)) begin
         bad++;
         $display("FAIL stall_first: pt_valid=%b pt_data=%h, required 1 %h", pt_valid, pt_data, 8'h5A ^ ks0);
      end
      ct_data = 8'hC3;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (ct_ready !== 1'b0 || pt_valid !== 1'b1 || pt_data !== (8'h5A ^ ks0)) begin
            bad++;
            $display("FAIL stall_hold%0d: ct_ready=%b pt_valid=%b pt_data=%h, required 0 1 %h",
                     i, ct_ready, pt_valid, pt_data, 8'h5A ^ ks0);
         end
         tick();
      end
      pt_ready = 1'b1;
      #1;
      total++;
      if (ct_ready !== 1'b1) begin
         bad++;
         $display("FAIL stall_release_ready: ct_ready=%b required 1", ct_ready);
      end
      tick();
      total++;
      if (pt_valid !== 1'b1 || pt_data !== (8'hC3 ^ ks1)) begin
         bad++;
         $display("FAIL stall_second: pt_valid=%b pt_data=%h, required 1 %h", pt_valid, pt_data, 8'hC3 ^ ks1);
      end
      ct_valid = 1'b0;
      tick();
      total++;
      if (pt_valid !== 1'b0) begin
         bad++;
         $display("FAIL stall_drain: pt_valid=%b required 0", pt_valid);
      end
   endtask

   task automatic test_abort_reload();
      logic [79:0] key_a, key_b, iv_b;
      logic [7:0] ks;
      key_a = 80'hFFEEDDCCBBAA99887766;
      key_b = 80'hFEDCBA98765432100102;
      iv_b  = 80'h13579BDF02468ACE1122;
      pulse_start();
      send_cfg(key_a, 80'h0, 0, 11);
      cfg_start = 1'b1;
      cfg_valid = 1'b1;
      cfg_data  = 8'hAA;
      tick();
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      total++;
      if ({busy, run, pt_valid} !== 3'b000) begin
         bad++;
         $display("FAIL abort_idle: busy=%b run=%b pt_valid=%b, required 000", busy, run, pt_valid);
      end
      send_cfg(key_b, iv_b, 0, 19);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL abort_reload_busy: busy=%b required 1", busy);
      end
      m_load(key_b, iv_b);
      wait_run("abort");
      pt_ready = 1'b1;
      ct_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ct_data = 8'(8'h11 * i);
         tick();
         m_byte(ks);
         total++;
         if (pt_data !== (8'(8'h11 * i) ^ ks)) begin
            bad++;
            $display("FAIL abort_byte%0d: pt_data=%h required %h", i, pt_data, 8'(8'h11 * i) ^ ks);
         end
      end
      ct_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_init();
      logic [79:0] key, iv;
      logic [7:0] ks;
      key = 80'h31415926535897932384;
      iv  = 80'h27182818284590452353;
      pulse_start();
      send_cfg(key, iv, 0, 19);
      repeat (70) tick();
      total++;
      if (busy !== 1'b1 || pt_data === 8'h00) begin
         bad++;
         $display("FAIL pre_reset: busy=%b pt_data=%h, required busy 1 and nonzero pt_data", busy, pt_data);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({ct_ready, pt_valid, pt_data, busy, run} !== 12'h000) begin
         bad++;
         $display("FAIL async_reset: ct_ready=%b pt_valid=%b pt_data=%h busy=%b run=%b, required all 0",
                  ct_ready, pt_valid, pt_data, busy, run);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      m_load(key, iv);
      send_cfg(key, iv, 0, 19);
      wait_run("post_reset");
      pt_ready = 1'b1;
      ct_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ct_data = 8'hF0;
         tick();
         m_byte(ks);
         total++;
         if (pt_valid !== 1'b1 || pt_data !== (8'hF0 ^ ks)) begin
            bad++;
            $display("FAIL post_reset_byte%0d: pt_valid=%b pt_data=%h, required 1 %h", i, pt_valid, pt_data, 8'hF0 ^ ks);
         end
      end
      ct_valid = 1'b0;
      tick();
   endtask

   initial begin
      rst_n     = 1'b0;
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = 8'h00;
      ct_valid  = 1'b0;
      ct_data   = 8'h00;
      pt_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      tick();
      test_zero_key();
      test_hello();
      test_stall();
      test_abort_reload();
      test_reset_mid_init();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
